// File: rtl/snd_pkg.sv
// Shared types and note table for the game sound sequencer.
// The game-mode enum mirrors the one owned by the game FSM.
package snd_pkg;

    typedef enum logic [1:0] {
        INIT = 2'd0,
        RUN  = 2'd1,
        WIN  = 2'd2,
        LOSE = 2'd3
    } MODE_TYPES;

    localparam int SND_DIV_W = 8;
    localparam int SND_DUR_W = 24;

    // Encoding order doubles as priority order: higher value wins.
    typedef enum logic [2:0] {
        SND_NONE = 3'd0,
        SND_GOOD = 3'd1,
        SND_BAD  = 3'd2,
        SND_WIN  = 3'd3,
        SND_LOSE = 3'd4
    } sound_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        PLAY = 2'd2,
        GAP  = 2'd3
    } fsm_t;

    typedef struct packed {
        logic [SND_DIV_W-1:0] div;
        logic [SND_DUR_W-1:0] dur;
        logic                 last;
    } note_t;

    localparam note_t NOTE_END = '{8'd0, 24'd1, 1'b1};

    // Rows: GOOD, BAD, WIN, LOSE. Durations in 12 MHz cycles.
    localparam note_t SND_ROM [0:3][0:3] = '{
        '{'{8'd109, 24'd4_000_000,  1'b1}, NOTE_END, NOTE_END, NOTE_END},
        '{'{8'd188, 24'd10_000_000, 1'b1}, NOTE_END, NOTE_END, NOTE_END},
        '{'{8'd188, 24'd2_000_000,  1'b0}, '{8'd150, 24'd2_000_000, 1'b0},
          '{8'd109, 24'd6_000_000,  1'b1}, NOTE_END},
        '{'{8'd150, 24'd3_000_000,  1'b0}, '{8'd188, 24'd3_000_000, 1'b0},
          '{8'd234, 24'd6_000_000,  1'b1}, NOTE_END}
    };

    // Request/pending vectors are ordered {LOSE, WIN, BAD, GOOD}.
    function automatic sound_t pick_top(input logic [3:0] bits);
        sound_t top;
        if (bits[3])      top = SND_LOSE;
        else if (bits[2]) top = SND_WIN;
        else if (bits[1]) top = SND_BAD;
        else if (bits[0]) top = SND_GOOD;
        else              top = SND_NONE;
        return top;
    endfunction

    function automatic logic [3:0] snd_bit(input sound_t s);
        logic [3:0] b;
        case (s)
            SND_GOOD: b = 4'b0001;
            SND_BAD:  b = 4'b0010;
            SND_WIN:  b = 4'b0100;
            SND_LOSE: b = 4'b1000;
            default:  b = 4'b0000;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/snd_rom.sv
// Combinational note lookup with duration scaling; a scaled duration
// of zero is forced to one so every note sounds for at least a cycle.
module snd_rom
    import snd_pkg::*;
#(
    parameter int DUR_SCALE_SH = 0
)(
    input  sound_t      snd,
    input  logic [1:0]  note_idx,
    output note_t       note
);

    note_t                raw_s;
    logic [2:0]           row_s;
    logic [SND_DUR_W-1:0] scaled_s;

    // Table read and duration scaling.
    always_comb begin
        row_s = 3'(snd) - 3'd1;
        if (snd != SND_NONE) begin
            raw_s = SND_ROM[row_s[1:0]][note_idx];
        end else begin
            raw_s = NOTE_END;
        end
        scaled_s  = raw_s.dur >> DUR_SCALE_SH;
        note.div  = raw_s.div;
        note.last = raw_s.last;
        if (scaled_s == '0) begin
            note.dur = SND_DUR_W'(1);
        end else begin
            note.dur = scaled_s;
        end
    end

endmodule

// File: rtl/sound_sequencer.sv
// Game sound arbiter and note sequencer driving the square-wave tone
// generator: priority LOSE > WIN > BAD > GOOD with preemption and pending bits.
module sound_sequencer
    import snd_pkg::*;
#(
    parameter int DIV_W        = SND_DIV_W,
    parameter int DUR_W        = SND_DUR_W,
    parameter int GAP_CYCLES   = 120000,
    parameter int DUR_SCALE_SH = 0
)(
    input  logic             clk,
    input  logic             nRst,
    input  MODE_TYPES        state,
    input  logic             goodColl,
    input  logic             badColl,
    output logic [DIV_W-1:0] osc_div,
    output logic             osc_en,
    output logic             busy,
    output logic [2:0]       cur_snd
);

    fsm_t             fsm_r;
    sound_t           snd_r;
    logic [1:0]       note_idx_r;
    logic [DUR_W-1:0] dur_cnt_r;
    logic [DUR_W-1:0] gap_cnt_r;
    logic             last_r;
    logic [3:0]       pend_r;
    MODE_TYPES        state_q_r;
    logic             armed_r;

    logic             win_req_s;
    logic             lose_req_s;
    logic [3:0]       req_s;
    logic [3:0]       all_s;
    logic [3:0]       pend_next_s;
    sound_t           req_top_s;
    sound_t           all_top_s;
    sound_t           launch_snd_s;
    logic             launch_s;
    logic             preempt_s;
    logic             play_done_s;
    note_t            rom_note_s;

    snd_rom #(.DUR_SCALE_SH(DUR_SCALE_SH)) u_rom (
        .snd      (snd_r),
        .note_idx (note_idx_r),
        .note     (rom_note_s)
    );

    // Request detection, arbitration and next pending set.
    always_comb begin
        // armed_r masks the first cycle after reset so a held mode does not retrigger.
        win_req_s   = armed_r && (state == WIN)  && (state_q_r != WIN);
        lose_req_s  = armed_r && (state == LOSE) && (state_q_r != LOSE);
        req_s       = {lose_req_s, win_req_s, badColl, goodColl};
        all_s       = pend_r | req_s;
        req_top_s   = pick_top(req_s);
        all_top_s   = pick_top(all_s);
        play_done_s = (fsm_r == PLAY) && (dur_cnt_r <= DUR_W'(1)) && last_r;
        preempt_s   = (fsm_r != IDLE) && (req_top_s != SND_NONE) && (req_top_s >= snd_r);
        if (preempt_s) begin
            launch_s     = 1'b1;
            launch_snd_s = req_top_s;
        end else if (((fsm_r == IDLE) || play_done_s) && (all_top_s != SND_NONE)) begin
            launch_s     = 1'b1;
            launch_snd_s = all_top_s;
        end else begin
            launch_s     = 1'b0;
            launch_snd_s = SND_NONE;
        end
        // Mode entries flush stale collision sounds.
        pend_next_s = all_s & ~snd_bit(launch_snd_s)
                      & ((win_req_s || lose_req_s) ? 4'b1100 : 4'b1111);
    end

    // Sequencer FSM with registered tone outputs.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            fsm_r      <= IDLE;
            snd_r      <= SND_NONE;
            note_idx_r <= 2'd0;
            dur_cnt_r  <= '0;
            gap_cnt_r  <= '0;
            last_r     <= 1'b0;
            pend_r     <= 4'b0000;
            state_q_r  <= INIT;
            armed_r    <= 1'b0;
            osc_div    <= '0;
            osc_en     <= 1'b0;
            busy       <= 1'b0;
            cur_snd    <= 3'd0;
        end else begin
            state_q_r <= state;
            armed_r   <= 1'b1;
            pend_r    <= pend_next_s;
            if (launch_s) begin
                fsm_r      <= LOAD;
                snd_r      <= launch_snd_s;
                note_idx_r <= 2'd0;
                osc_en     <= 1'b0;
                busy       <= 1'b1;
                cur_snd    <= launch_snd_s;
            end else begin
                case (fsm_r)
                    IDLE: begin
                        osc_en  <= 1'b0;
                        busy    <= 1'b0;
                        cur_snd <= SND_NONE;
                    end
                    LOAD: begin
                        fsm_r     <= PLAY;
                        osc_div   <= DIV_W'(rom_note_s.div);
                        dur_cnt_r <= DUR_W'(rom_note_s.dur);
                        last_r    <= rom_note_s.last;
                        osc_en    <= 1'b1;
                    end
                    PLAY: begin
                        if (dur_cnt_r > DUR_W'(1)) begin
                            dur_cnt_r <= dur_cnt_r - DUR_W'(1);
                        end else if (!last_r) begin
                            fsm_r     <= GAP;
                            gap_cnt_r <= DUR_W'(GAP_CYCLES);
                            osc_en    <= 1'b0;
                        end else begin
                            fsm_r   <= IDLE;
                            snd_r   <= SND_NONE;
                            osc_en  <= 1'b0;
                            busy    <= 1'b0;
                            cur_snd <= SND_NONE;
                        end
                    end
                    GAP: begin
                        if (gap_cnt_r > DUR_W'(1)) begin
                            gap_cnt_r <= gap_cnt_r - DUR_W'(1);
                        end else begin
                            fsm_r <= LOAD;
                            if (note_idx_r != 2'd3) begin
                                note_idx_r <= note_idx_r + 2'd1;
                            end else begin
                                note_idx_r <= note_idx_r;
                            end
                        end
                    end
                    default: begin
                        fsm_r   <= IDLE;
                        snd_r   <= SND_NONE;
                        osc_en  <= 1'b0;
                        busy    <= 1'b0;
                        cur_snd <= SND_NONE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sound_sequencer.sv
// Scoreboard bench for sound_sequencer: a timeline model predicts every
// output cycle; a monitor compares the DUT against the queued predictions.
module tb_sound_sequencer;
    import snd_pkg::*;

    localparam int GAP = 8;
    localparam int SH  = 16;

    typedef struct packed {
        logic       en;
        logic [7:0] div;
        logic       busy;
        logic [2:0] snd;
    } exp_t;

    logic       clk = 1'b0;
    logic       nRst;
    MODE_TYPES  state;
    logic       goodColl;
    logic       badColl;
    logic [7:0] osc_div;
    logic       osc_en;
    logic       busy;
    logic [2:0] cur_snd;

    sound_sequencer #(
        .DIV_W(8), .DUR_W(24), .GAP_CYCLES(GAP), .DUR_SCALE_SH(SH)
    ) dut (
        .clk(clk), .nRst(nRst), .state(state), .goodColl(goodColl), .badColl(badColl),
        .osc_div(osc_div), .osc_en(osc_en), .busy(busy), .cur_snd(cur_snd)
    );

    always #5 clk = ~clk;

    int        checks = 0;
    int        failures = 0;
    exp_t      exp_q[$];
    bit        chk_en = 1'b0;
    int        div_tab[5][3];
    int        dur_tab[5][3];
    int        n_notes[5];
    int        m_cur, m_t0, m_cyc;
    bit [4:0]  m_pend;
    bit        m_armed;
    MODE_TYPES m_mode_q;
    MODE_TYPES cur_mode;

    function automatic int sdur(input int s, input int k);
        int d = dur_tab[s][k] >> SH;
        return (d < 1) ? 1 : d;
    endfunction

    // Offset of the final playing cycle, counted from the sound's first LOAD cycle.
    function automatic int end_off(input int s);
        int pos = 0;
        for (int k = 0; k < n_notes[s]; k++) begin
            pos += 1 + sdur(s, k);
            if (k < n_notes[s] - 1) pos += GAP;
        end
        return pos - 1;
    endfunction

    function automatic exp_t out_at(input int s, input int t0, input int c);
        exp_t e = '0;
        int off = c - t0;
        int pos = 0;
        if (s == 0) return e;
        e.busy = 1'b1;
        e.snd  = 3'(s);
        for (int k = 0; k < n_notes[s]; k++) begin
            int d = sdur(s, k);
            if (off > pos && off <= pos + d) begin
                e.en  = 1'b1;
                e.div = 8'(div_tab[s][k]);
            end
            pos += 1 + d;
            if (k < n_notes[s] - 1) pos += GAP;
        end
        return e;
    endfunction

    function automatic int highest(input bit [4:0] v);
        for (int i = 4; i >= 1; i--) if (v[i]) return i;
        return 0;
    endfunction

    task automatic model_reset();
        m_cur = 0; m_t0 = 0; m_pend = '0; m_armed = 1'b0; m_mode_q = INIT;
    endtask

    // Advance the model by one cycle of inputs; queue the output for the next cycle.
    task automatic model_step(input bit g, input bit b, input MODE_TYPES m);
        bit [4:0] req = '0;
        int top;
        req[1] = g;
        req[2] = b;
        req[3] = m_armed && (m == WIN) && (m_mode_q != WIN);
        req[4] = m_armed && (m == LOSE) && (m_mode_q != LOSE);
        top = highest(req);
        if (m_cur != 0 && top != 0 && top >= m_cur) begin
            for (int i = 1; i <= 4; i++) if (req[i] && i != top) m_pend[i] = 1'b1;
            m_cur = top;
            m_t0  = m_cyc + 1;
        end else begin
            m_pend |= req;
            if (m_cur == 0 || (m_cyc - m_t0) == end_off(m_cur)) begin
                int tp = highest(m_pend);
                if (tp != 0) m_pend[tp] = 1'b0;
                m_cur = tp;
                m_t0  = m_cyc + 1;
            end
        end
        if (req[3] || req[4]) begin
            m_pend[1] = 1'b0;
            m_pend[2] = 1'b0;
        end
        m_mode_q = m;
        m_armed  = 1'b1;
        m_cyc++;
        exp_q.push_back(out_at(m_cur, m_t0, m_cyc));
    endtask

    task automatic tick(input bit g, input bit b);
        @(negedge clk);
        goodColl = g;
        badColl  = b;
        state    = cur_mode;
        model_step(g, b, cur_mode);
    endtask

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d t=%0t", name, got, want, $time);
        end
    endtask

    // Monitor: pops one prediction per cycle and compares.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (chk_en) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL scoreboard_empty t=%0t", $time);
                end else begin
                    e = exp_q.pop_front();
                    if (osc_en !== e.en || busy !== e.busy || cur_snd !== e.snd ||
                        (e.en && osc_div !== e.div)) begin
                        failures++;
                        $display("FAIL cycle_out t=%0t got en=%0b div=%0d busy=%0b snd=%0d want en=%0b div=%0d busy=%0b snd=%0d",
                                 $time, osc_en, osc_div, busy, cur_snd, e.en, e.div, e.busy, e.snd);
                    end
                end
            end
        end
    end

    initial begin
        int guard;
        div_tab = '{default: '{default: 0}};
        dur_tab = '{default: '{default: 0}};
        n_notes = '{default: 0};
        n_notes[1] = 1; div_tab[1][0] = 109; dur_tab[1][0] = 4_000_000;
        n_notes[2] = 1; div_tab[2][0] = 188; dur_tab[2][0] = 10_000_000;
        n_notes[3] = 3;
        div_tab[3][0] = 188; dur_tab[3][0] = 2_000_000;
        div_tab[3][1] = 150; dur_tab[3][1] = 2_000_000;
        div_tab[3][2] = 109; dur_tab[3][2] = 6_000_000;
        n_notes[4] = 3;
        div_tab[4][0] = 150; dur_tab[4][0] = 3_000_000;
        div_tab[4][1] = 188; dur_tab[4][1] = 3_000_000;
        div_tab[4][2] = 234; dur_tab[4][2] = 6_000_000;

        nRst = 1'b0; goodColl = 1'b0; badColl = 1'b0;
        cur_mode = RUN; state = RUN; m_cyc = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #2;
        chk("rst_osc_en", int'(osc_en), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_cur_snd", int'(cur_snd), 0);
        chk("rst_osc_div", int'(osc_div), 0);
        @(posedge clk);
        #3;
        nRst = 1'b1;
        chk_en = 1'b1;

        // Single GOOD, then simultaneous GOOD+BAD.
        repeat (10) tick(1'b0, 1'b0);
        tick(1'b1, 1'b0);
        repeat (80) tick(1'b0, 1'b0);
        tick(1'b1, 1'b1);
        repeat (250) tick(1'b0, 1'b0);
        // BAD preempts GOOD mid-note.
        tick(1'b1, 1'b0);
        repeat (20) tick(1'b0, 1'b0);
        tick(1'b0, 1'b1);
        repeat (200) tick(1'b0, 1'b0);
        // Duplicate GOOD requests during BAD collapse into one.
        tick(1'b0, 1'b1);
        repeat (10) tick(1'b0, 1'b0);
        tick(1'b1, 1'b0);
        repeat (10) tick(1'b0, 1'b0);
        tick(1'b1, 1'b0);
        repeat (250) tick(1'b0, 1'b0);
        // GOOD pending behind BAD, then LOSE entry preempts and flushes it.
        tick(1'b0, 1'b1);
        repeat (10) tick(1'b0, 1'b0);
        tick(1'b1, 1'b0);
        repeat (10) tick(1'b0, 1'b0);
        cur_mode = LOSE;
        guard = 0;
        while (!(m_cur == 4 && (m_cyc - m_t0) == 48) && guard < 1000) begin
            tick(1'b0, 1'b0);
            guard++;
        end
        chk("lose_gap_reached", int'(guard < 1000), 1);
        // Asynchronous reset in the middle of the first LOSE gap.
        @(posedge clk);
        #3;
        chk_en = 1'b0;
        nRst = 1'b0;
        #1;
        chk("async_osc_en", int'(osc_en), 0);
        chk("async_busy", int'(busy), 0);
        chk("async_cur_snd", int'(cur_snd), 0);
        chk("async_osc_div", int'(osc_div), 0);
        exp_q.delete();
        model_reset();
        repeat (3) @(posedge clk);
        #3;
        nRst = 1'b1;
        chk_en = 1'b1;
        repeat (30) tick(1'b0, 1'b0);
        tick(1'b1, 1'b0);
        repeat (80) tick(1'b0, 1'b0);

        // Randomised requests and mode changes.
        cur_mode = RUN;
        for (int i = 0; i < 6000; i++) begin
            if ($urandom_range(0, 299) == 0) cur_mode = MODE_TYPES'(2'($urandom_range(0, 3)));
            tick($urandom_range(0, 39) == 0, $urandom_range(0, 59) == 0);
        end

        @(posedge clk);
        #2;
        chk_en = 1'b0;
        chk("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
